seq_alu_router: RTL and testbench
=================================

SEQ_ALU_ROUTER -- requirements
Module: seq_alu_router

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width (2..16).
REQ-002 SHALL have parameter OUT_CH, default 4, number of registered output channels (1..32).
REQ-003 SHALL have a single clock and a synchronous, active-low reset.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 instruction  input  16  [15:13] opcode, [12:8] destination channel, [7:0] reserved (ignored).
REQ-007 data0  input  DATA_W  operand A.
REQ-008 data1  input  DATA_W  operand B.
REQ-009 in_valid  input  1  instruction/operands valid.
REQ-010 in_ready  output  1  block can accept an instruction.
REQ-011 out_bus  output  OUT_CH*DATA_W  concatenated channel registers, channel k at bits [k*DATA_W +: DATA_W].
REQ-012 done  output  1  one-cycle pulse: result written.
REQ-013 overflow_flag  output  1  overflow of last completed op.
REQ-014 zero_flag  output  1  last completed result equal to zero.
REQ-015 dest_err  output  1  one-cycle pulse: destination channel out of range.

Function
REQ-016 Transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; operands and instruction SHALL be captured at that edge.
REQ-017 Opcodes SHALL be: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 MUL (unsigned, low DATA_W bits), 110 NOT A, 111 PASS B.
REQ-018 FSM states SHALL be IDLE, MUL, WRITE; in_ready=1 only in IDLE.
REQ-019 Non-MUL op accepted at edge N SHALL go IDLE->WRITE; the channel register, flags and done SHALL update/assert at edge N+1 and the FSM SHALL return to IDLE (in_ready high again at N+1).
REQ-020 MUL SHALL be a shift-add iterating DATA_W cycles in state MUL, then WRITE; result, flags and done SHALL update at edge N+DATA_W+1.
REQ-021 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-022 Overflow: ADD = carry-out; SUB = borrow (A<B unsigned); MUL = any nonzero bit above DATA_W-1 of the full product; logic/NOT/PASS = 0.
REQ-023 zero_flag SHALL be computed on the value actually written (after saturation if enabled).
REQ-024 Flags SHALL update only on done and hold until the next done.
REQ-025 Destination >= OUT_CH SHALL write no channel, leave flags unchanged, suppress done, and pulse dest_err at the same edge done would have occurred.
REQ-026 Channels not addressed SHALL hold their value.

Reset
REQ-027 On rst_n=0 at an edge: all channel registers 0, overflow_flag 0, zero_flag 0, done 0, dest_err 0, FSM IDLE, in_ready 1 from the first edge after release.
REQ-028 Reset during MUL or WRITE SHALL abort the operation with no done and no channel write.

Configuration
REQ-029 Macro SEQ_ALU_SAT_EN: when defined, ADD overflow SHALL write all-ones, SUB borrow SHALL write 0, MUL overflow SHALL write all-ones (overflow_flag still 1); when undefined, results SHALL wrap modulo 2^DATA_W.

Verification
REQ-030 DATA_W=8: ADD 255+1 to ch0 -> done at N+1, ch0=0x00, overflow=1, zero=1 (with SEQ_ALU_SAT_EN: ch0=0xFF, zero=0).
REQ-031 SUB 1-2 to ch3 -> ch3=0xFF, overflow=1 (SAT: ch3=0x00, zero=1); ch0..ch2 unchanged.
REQ-032 MUL 16*17 to ch1 -> in_ready low 9 cycles, done at N+9, ch1=0x10, overflow=1; second in_valid during busy ignored.
REQ-033 PASS 0x2A, dest=4 with OUT_CH=4 -> dest_err pulse at N+1, no done, out_bus and flags unchanged.
REQ-034 rst_n=0 at third cycle of MUL -> no done, all outputs 0, in_ready 1 after release.

Source files
------------

// File: rtl/seq_alu_router.sv
// Sequential ALU that routes each result into one of OUT_CH output channel registers.
// Optional build macro SEQ_ALU_SAT_EN: saturate ADD/SUB/MUL results instead of wrapping.
module seq_alu_router #(
    parameter int DATA_W = 8,
    parameter int OUT_CH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              instruction,
    input  logic [DATA_W-1:0]        data0,
    input  logic [DATA_W-1:0]        data1,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OUT_CH*DATA_W-1:0] out_bus,
    output logic                     done,
    output logic                     overflow_flag,
    output logic                     zero_flag,
    output logic                     dest_err
);

    typedef enum logic [1:0] {IDLE, MUL, WRITE} state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;
    localparam logic [4:0] MUL_LAST = 5'(DATA_W - 1);

    state_t state, state_nxt;

    logic [2:0]          op_q;
    logic [4:0]          dest_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [2*DATA_W-1:0] prod_q, mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [4:0]          cnt_q;

    logic [DATA_W:0]     sum, diff;
    logic [DATA_W-1:0]   raw, res;
    logic                ovf;
    logic                dest_ok;
    logic                accept;
    logic                unused_bits;

    logic [DATA_W-1:0]   ch_q [OUT_CH];

    assign unused_bits = ^instruction[7:0];
    assign in_ready    = (state == IDLE);
    assign accept      = in_valid && in_ready;
    assign dest_ok     = (int'(dest_q) < OUT_CH);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (instruction[15:13] == OP_MUL) ? MUL : WRITE;
            MUL:     if (cnt_q == MUL_LAST) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and shift-add multiplier; pure datapath, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= instruction[15:13];
            dest_q   <= instruction[12:8];
            a_q      <= data0;
            b_q      <= data1;
            prod_q   <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, data0};
            mplier_q <= data1;
            cnt_q    <= '0;
        end else if (state == MUL) begin
            if (mplier_q[0]) prod_q <= prod_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 5'd1;
        end
    end

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        raw = '0;
        ovf = 1'b0;
        case (op_q)
            OP_ADD:  begin raw = sum[DATA_W-1:0];  ovf = sum[DATA_W]; end
            OP_SUB:  begin raw = diff[DATA_W-1:0]; ovf = (a_q < b_q); end
            OP_AND:  raw = a_q & b_q;
            OP_OR:   raw = a_q | b_q;
            OP_XOR:  raw = a_q ^ b_q;
            OP_MUL:  begin raw = prod_q[DATA_W-1:0]; ovf = |prod_q[2*DATA_W-1:DATA_W]; end
            OP_NOT:  raw = ~a_q;
            OP_PASS: raw = b_q;
            default: raw = '0;
        endcase
    end

`ifdef SEQ_ALU_SAT_EN
    function automatic logic [DATA_W-1:0] saturate(input logic [2:0] op,
                                                   input logic [DATA_W-1:0] val,
                                                   input logic of);
        if (of && (op == OP_ADD || op == OP_MUL)) return '1;
        if (of && op == OP_SUB) return '0;
        return val;
    endfunction
    assign res = saturate(op_q, raw, ovf);
`else
    assign res = raw;
`endif

    // Control, flags and channel registers; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            done          <= 1'b0;
            dest_err      <= 1'b0;
            overflow_flag <= 1'b0;
            zero_flag     <= 1'b0;
            for (int k = 0; k < OUT_CH; k++) ch_q[k] <= '0;
        end else begin
            state    <= state_nxt;
            done     <= (state == WRITE) && dest_ok;
            dest_err <= (state == WRITE) && !dest_ok;
            if (state == WRITE && dest_ok) begin
                overflow_flag <= ovf;
                zero_flag     <= (res == '0);
                for (int k = 0; k < OUT_CH; k++)
                    if (dest_q == 5'(k)) ch_q[k] <= res;
            end
        end
    end

    for (genvar g = 0; g < OUT_CH; g++) begin : g_bus
        assign out_bus[g*DATA_W +: DATA_W] = ch_q[g];
    end

endmodule

// File: tb/tb_seq_alu_router.sv
// Scoreboard bench for seq_alu_router (DATA_W=8, OUT_CH=4); honours SEQ_ALU_SAT_EN if defined.
module tb_seq_alu_router;

    logic        clk;
    logic        rst_n;
    logic [15:0] instruction;
    logic [7:0]  data0, data1;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_bus;
    logic        done, overflow_flag, zero_flag, dest_err;

    seq_alu_router #(.DATA_W(8), .OUT_CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .data0(data0), .data1(data1), .in_valid(in_valid), .in_ready(in_ready),
        .out_bus(out_bus), .done(done), .overflow_flag(overflow_flag),
        .zero_flag(zero_flag), .dest_err(dest_err)
    );

    typedef struct {
        logic [31:0] bus;
        logic        ovf;
        logic        zero;
        logic        err;
        int          lat;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] m_ch [4];
    logic       m_ovf, m_zero;
    int         total = 0;
    int         bad = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: push the expected post-op state; ops are strictly sequential.
    task automatic send(input logic [2:0] op, input logic [4:0] dest,
                        input logic [7:0] a, input logic [7:0] b, input bit track);
        int   ia, ib;
        logic [7:0] r;
        logic o;
        sb_t  e;
        ia = a; ib = b; o = 0;
        case (op)
            3'd0: begin r = 8'((ia + ib) % 256);       o = (ia + ib) > 255; end
            3'd1: begin r = 8'((ia - ib + 256) % 256); o = ia < ib; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = 8'((ia * ib) % 256);       o = (ia * ib) > 255; end
            3'd6: r = ~a;
            default: r = b;
        endcase
`ifdef SEQ_ALU_SAT_EN
        if (o && (op == 3'd0 || op == 3'd5)) r = 8'hFF;
        if (o && op == 3'd1) r = 8'h00;
`endif
        if (track) begin
            e.err = (dest >= 5'd4);
            if (!e.err) begin
                m_ch[dest[1:0]] = r;
                m_ovf = o;
                m_zero = (r == 8'h00);
            end
            e.bus  = {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
            e.ovf  = m_ovf;
            e.zero = m_zero;
            e.lat  = (op == 3'd5) ? 9 : 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        instruction = {op, dest, 8'hA5};
        data0 = a;
        data1 = b;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    // Waits (bounded) for done or dest_err; optionally pokes a second request while busy.
    task automatic collect(output int lat, output int busy, output logic gd,
                           output logic ge, input bit poke);
        lat = 0; busy = 0; gd = 0; ge = 0;
        while (lat < 40) begin
            if (!in_ready) busy++;
            if (poke && lat == 2) begin
                instruction = {3'd0, 5'd2, 8'h00};
                data0 = 8'h11;
                data1 = 8'h22;
                in_valid = 1;
            end
            @(posedge clk);
            #1;
            in_valid = 0;
            lat++;
            gd = done;
            ge = dest_err;
            if (done || dest_err) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_bus !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h exp=%h", out_bus, 32'h0); end
        total++; if ({done, dest_err, overflow_flag, zero_flag} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {done, dest_err, overflow_flag, zero_flag}); end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        for (int k = 0; k < 4; k++) m_ch[k] = 8'h00;
        m_ovf = 0; m_zero = 0;
    endtask

    task automatic test_add();
        int lat, busy; logic gd, ge; sb_t e;
        send(3'd0, 5'd0, 8'd255, 8'd1, 1);
        collect(lat, busy, gd, ge, 0);
        e = sb_q.pop_front();
        total++; if (lat !== e.lat || gd !== 1'b1) begin bad++; $display("FAIL add_lat got=%0d/%b exp=%0d/1", lat, gd, e.lat); end
        total++; if (out_bus !== e.bus) begin bad++; $display("FAIL add_bus got=%h exp=%h", out_bus, e.bus); end
        total++; if ({overflow_flag, zero_flag} !== {e.ovf, e.zero}) begin
            bad++; $display("FAIL add_flags got=%b%b exp=%b%b", overflow_flag, zero_flag, e.ovf, e.zero); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL add_pulse got=%b exp=0", done); end
        total++; if ({overflow_flag, zero_flag} !== {e.ovf, e.zero}) begin
            bad++; $display("FAIL add_hold got=%b%b exp=%b%b", overflow_flag, zero_flag, e.ovf, e.zero); end
    endtask

    task automatic test_sub();
        int lat, busy; logic gd, ge; sb_t e;
        send(3'd0, 5'd2, 8'd3, 8'd4, 1);
        collect(lat, busy, gd, ge, 0);
        e = sb_q.pop_front();
        total++; if (out_bus !== e.bus) begin bad++; $display("FAIL pre_sub_bus got=%h exp=%h", out_bus, e.bus); end
        send(3'd1, 5'd3, 8'd1, 8'd2, 1);
        collect(lat, busy, gd, ge, 0);
        e = sb_q.pop_front();
        total++; if (lat !== e.lat || gd !== 1'b1) begin bad++; $display("FAIL sub_lat got=%0d/%b exp=%0d/1", lat, gd, e.lat); end
        total++; if (out_bus !== e.bus) begin bad++; $display("FAIL sub_bus got=%h exp=%h", out_bus, e.bus); end
        total++; if ({overflow_flag, zero_flag} !== {e.ovf, e.zero}) begin
            bad++; $display("FAIL sub_flags got=%b%b exp=%b%b", overflow_flag, zero_flag, e.ovf, e.zero); end
    endtask

    task automatic test_logic();
        int lat, busy; logic gd, ge; sb_t e;
        logic [2:0] ops [5];
        ops = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        for (int i = 0; i < 5; i++) begin
            send(ops[i], 5'(i % 4), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
            collect(lat, busy, gd, ge, 0);
            e = sb_q.pop_front();
            total++; if (lat !== e.lat || gd !== 1'b1 || ge !== 1'b0) begin
                bad++; $display("FAIL logic_lat op=%0d got=%0d/%b exp=%0d/1", ops[i], lat, gd, e.lat); end
            total++; if (out_bus !== e.bus || {overflow_flag, zero_flag} !== {e.ovf, e.zero}) begin
                bad++; $display("FAIL logic_res op=%0d got=%h %b%b exp=%h %b%b", ops[i], out_bus,
                                overflow_flag, zero_flag, e.bus, e.ovf, e.zero); end
        end
    endtask

    task automatic test_mul();
        int lat, busy; logic gd, ge; sb_t e;
        send(3'd5, 5'd1, 8'd16, 8'd17, 1);
        collect(lat, busy, gd, ge, 1);
        e = sb_q.pop_front();
        total++; if (lat !== 9 || gd !== 1'b1) begin bad++; $display("FAIL mul_lat got=%0d/%b exp=9/1", lat, gd); end
        total++; if (busy !== 9) begin bad++; $display("FAIL mul_busy got=%0d exp=9", busy); end
        total++; if (out_bus !== e.bus) begin bad++; $display("FAIL mul_bus got=%h exp=%h", out_bus, e.bus); end
        total++; if ({overflow_flag, zero_flag} !== {e.ovf, e.zero}) begin
            bad++; $display("FAIL mul_flags got=%b%b exp=%b%b", overflow_flag, zero_flag, e.ovf, e.zero); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (done !== 1'b0 || out_bus !== e.bus) begin
            bad++; $display("FAIL mul_ignored got=%b %h exp=0 %h", done, out_bus, e.bus); end
    endtask

    task automatic test_dest_err();
        int lat, busy; logic gd, ge; sb_t e;
        logic [4:0] dests [2];
        dests = '{5'd4, 5'd31};
        for (int i = 0; i < 2; i++) begin
            send(3'd7, dests[i], 8'h00, 8'h2A, 1);
            collect(lat, busy, gd, ge, 0);
            e = sb_q.pop_front();
            total++; if (lat !== 1 || ge !== 1'b1 || gd !== 1'b0) begin
                bad++; $display("FAIL dest_err_pulse got=%0d err=%b done=%b exp=1 err=1 done=0", lat, ge, gd); end
            total++; if (out_bus !== e.bus || {overflow_flag, zero_flag} !== {e.ovf, e.zero}) begin
                bad++; $display("FAIL dest_err_hold got=%h %b%b exp=%h %b%b", out_bus,
                                overflow_flag, zero_flag, e.bus, e.ovf, e.zero); end
            @(posedge clk);
            #1;
            total++; if (dest_err !== 1'b0) begin bad++; $display("FAIL dest_err_once got=%b exp=0", dest_err); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, busy; logic gd, ge; sb_t e;
        logic [2:0] op;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            send(op, 5'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
            collect(lat, busy, gd, ge, 0);
            e = sb_q.pop_front();
            total++; if (lat !== e.lat || gd !== 1'b1) begin
                bad++; $display("FAIL b2b_lat op=%0d got=%0d/%b exp=%0d/1", op, lat, gd, e.lat); end
            total++; if (out_bus !== e.bus || {overflow_flag, zero_flag} !== {e.ovf, e.zero}) begin
                bad++; $display("FAIL b2b_res op=%0d got=%h %b%b exp=%h %b%b", op, out_bus,
                                overflow_flag, zero_flag, e.bus, e.ovf, e.zero); end
        end
    endtask

    task automatic test_mid_reset();
        int lat, busy; logic gd, ge; sb_t e;
        logic seen;
        send(3'd0, 5'd0, 8'd5, 8'd6, 1);
        collect(lat, busy, gd, ge, 0);
        e = sb_q.pop_front();
        total++; if (out_bus !== e.bus) begin bad++; $display("FAIL pre_rst_bus got=%h exp=%h", out_bus, e.bus); end
        send(3'd5, 5'd1, 8'd16, 8'd17, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        total++; if (out_bus !== 32'h0 || {done, dest_err, overflow_flag, zero_flag} !== 4'b0000) begin
            bad++; $display("FAIL mid_rst_clear got=%h %b exp=0 0000", out_bus,
                            {done, dest_err, overflow_flag, zero_flag}); end
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || dest_err) seen = 1;
        end
        total++; if (seen !== 1'b0 || out_bus !== 32'h0) begin
            bad++; $display("FAIL mid_rst_abort got=%b %h exp=0 0", seen, out_bus); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", in_ready); end
        for (int k = 0; k < 4; k++) m_ch[k] = 8'h00;
        m_ovf = 0; m_zero = 0;
        send(3'd4, 5'd2, 8'h5A, 8'h0F, 1);
        collect(lat, busy, gd, ge, 0);
        e = sb_q.pop_front();
        total++; if (gd !== 1'b1 || out_bus !== e.bus) begin
            bad++; $display("FAIL post_rst_op got=%b %h exp=1 %h", gd, out_bus, e.bus); end
    endtask

    initial begin
        rst_n = 0;
        in_valid = 0;
        instruction = 16'h0;
        data0 = 8'h0;
        data1 = 8'h0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_mul();
        test_dest_err();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
